// File: rtl/ext_irq_ctrl.sv
// External IRQ controller: synchronise and debounce switch inputs, latch level/edge events into
// pending bits, mask them toward the CPU, and expose PENDING/MASK/MODE/ACTIVE on the iomem bus.
module ext_irq_ctrl #(
    parameter int NUM_SRC  = 3,
    parameter int DEBOUNCE = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] sw,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    output logic [NUM_SRC-1:0] irq_o,
    output logic               irq_any
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t state_q, state_d;

    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    logic [NUM_SRC-1:0] filt_q, filt_d, fprev_q;
    logic [CW-1:0]      cnt_q [NUM_SRC];
    logic [CW-1:0]      cnt_d [NUM_SRC];

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;
    logic               irq_any_q, irq_any_d;

    logic [NUM_SRC-1:0] event_vec, req_vec, clr_vec;
    logic               wr_en, act_vld;
    logic [2:0]         act_idx;
    logic [1:0]         reg_sel;
    logic [31:0]        rd_dat;
    logic               unused_bits;

    assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wstrb[3:1],
                           iomem_wdata[31:NUM_SRC]};

    // Debounce: a differing input must persist DEBOUNCE sampled cycles before the filter follows.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign event_vec = (mode_q & filt_q & ~fprev_q) | (~mode_q & filt_q);
    assign req_vec   = pending_q & mask_q;
    assign reg_sel   = iomem_addr[3:2];
    assign wr_en     = (state_q == ST_ACK) && iomem_valid && iomem_wstrb[0];

    always_comb begin
        act_vld = 1'b0;
        act_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                act_vld = 1'b1;
                act_idx = 3'(i);
            end
        end
    end

    // Set wins over a same-cycle write-1-to-clear.
    always_comb begin
        clr_vec   = '0;
        mask_d    = mask_q;
        mode_d    = mode_q;
        if (wr_en) begin
            case (reg_sel)
                2'd0:    clr_vec = iomem_wdata[NUM_SRC-1:0];
                2'd1:    mask_d  = iomem_wdata[NUM_SRC-1:0];
                2'd2:    mode_d  = iomem_wdata[NUM_SRC-1:0];
                default: ;
            endcase
        end
        pending_d = (pending_q & ~clr_vec) | event_vec;
        irq_d     = req_vec;
        irq_any_d = |req_vec;
    end

    always_comb begin
        case (reg_sel)
            2'd0:    rd_dat = 32'(pending_q);
            2'd1:    rd_dat = 32'(mask_q);
            2'd2:    rd_dat = 32'(mode_q);
            default: rd_dat = {act_vld, 28'd0, act_idx};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        iomem_ready = 1'b0;
        iomem_rdata = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (iomem_valid) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                iomem_ready = 1'b1;
                iomem_rdata = rd_dat;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            fprev_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            irq_q     <= '0;
            irq_any_q <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sync1_q   <= sw;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            fprev_q   <= filt_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            irq_any_q <= irq_any_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq_o   = irq_q;
    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed and randomized bench for ext_irq_ctrl against a window-based behavioural model.
module tb_ext_irq_ctrl;

    localparam int N = 3;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  sw = '1;
    logic          iomem_valid = 1'b0;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb = 4'd0;
    logic [31:0]   iomem_addr = 32'd0;
    logic [31:0]   iomem_wdata = 32'd0;
    logic [31:0]   iomem_rdata;
    logic [N-1:0]  irq_o;
    logic          irq_any;

    int checks = 0;
    int errors = 0;

    ext_irq_ctrl #(.NUM_SRC(N), .DEBOUNCE(D)) dut (
        .clk(clk), .resetn(resetn), .sw(sw),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .irq_o(irq_o), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    // Behavioural model: the filter follows the switch once the last D synchronised samples
    // all disagree with it; samples reach the filter decision two edges after capture.
    logic [N-1:0] m_pend = '0, m_mask = '0, m_mode = '0, m_irq = '0;
    logic [N-1:0] m_filt = '0, m_fprev = '0;
    logic [N-1:0] swq [$];
    logic         m_wr_vld = 1'b0;
    logic [1:0]   m_wr_addr = 2'd0;
    logic [31:0]  m_wr_dat = 32'd0;
    logic [3:0]   m_wr_strb = 4'd0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_irq = '0; m_filt = '0; m_fprev = '0;
            swq.delete();
            repeat (D + 2) swq.push_back('0);
        end else begin
            logic [N-1:0] ev, clr;
            ev  = (m_mode & m_filt & ~m_fprev) | (~m_mode & m_filt);
            clr = '0;
            if (m_wr_vld && m_wr_strb[0] && m_wr_addr == 2'd0) clr = m_wr_dat[N-1:0];
            m_irq  = m_pend & m_mask;
            m_pend = (m_pend & ~clr) | ev;
            if (m_wr_vld && m_wr_strb[0] && m_wr_addr == 2'd1) m_mask = m_wr_dat[N-1:0];
            if (m_wr_vld && m_wr_strb[0] && m_wr_addr == 2'd2) m_mode = m_wr_dat[N-1:0];
            m_fprev = m_filt;
            swq.push_front(sw);
            void'(swq.pop_back());
            for (int i = 0; i < N; i++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) begin
                    if (swq[k][i] === m_filt[i]) all_diff = 1'b0;
                end
                if (all_diff) m_filt[i] = ~m_filt[i];
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [N-1:0] req;
        logic [31:0]  r;
        bit           found;
        req = m_pend & m_mask;
        r = 32'd0;
        found = 1'b0;
        case (a)
            2'd0: r = 32'(m_pend);
            2'd1: r = 32'(m_mask);
            2'd2: r = 32'(m_mode);
            default: begin
                for (int i = 0; i < N; i++) begin
                    if (req[i] && !found) begin
                        r = 32'h8000_0000 + 32'(i);
                        found = 1'b1;
                    end
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("irq_o", 32'(irq_o), 32'(m_irq));
        chk("irq_any", 32'(irq_any), 32'(|m_irq));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        iomem_valid = 1'b1; iomem_addr = {28'd0, a, 2'b00}; iomem_wdata = d; iomem_wstrb = s;
        tick();
        chk("wr_ready", 32'(iomem_ready), 32'd1);
        m_wr_vld = 1'b1; m_wr_addr = a; m_wr_dat = d; m_wr_strb = s;
        tick();
        m_wr_vld = 1'b0;
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        chk("wr_ready_drop", 32'(iomem_ready), 32'd0);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] obs, output logic [31:0] expv);
        iomem_valid = 1'b1; iomem_addr = {28'd0, a, 2'b00}; iomem_wstrb = 4'd0;
        tick();
        chk("rd_ready", 32'(iomem_ready), 32'd1);
        obs  = iomem_rdata;
        expv = m_read(a);
        tick();
        iomem_valid = 1'b0;
        chk("rd_ready_drop", 32'(iomem_ready), 32'd0);
        chk("rdata_idle", iomem_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd_obs, rd_exp;
        int n;

        // Reset with all switches high
        repeat (3) tick();
        chk("rst_irq_o", 32'(irq_o), 32'd0);
        chk("rst_irq_any", 32'(irq_any), 32'd0);
        chk("rst_ready", 32'(iomem_ready), 32'd0);
        sw = '0;
        resetn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd_obs, rd_exp);
            chk("rst_reg", rd_obs, 32'd0);
        end

        // Debounce latency, edge mode on source 0
        bus_write(2'd1, 32'h1, 4'b0001);
        bus_write(2'd2, 32'h1, 4'b0001);
        sw[0] = 1'b1;
        n = 0;
        while (n < 20 && !irq_o[0]) begin
            tick();
            n++;
        end
        chk("irq_latency", 32'(n), 32'(D + 4));
        sw[0] = 1'b0;
        repeat (12) tick();
        bus_write(2'd0, 32'h1, 4'b0001);
        sw[0] = 1'b1;
        repeat (3) tick();
        sw[0] = 1'b0;
        repeat (12) tick();
        bus_read(2'd0, rd_obs, rd_exp);
        chk("glitch_pending", rd_obs, 32'd0);
        chk("glitch_model", rd_obs, rd_exp);

        // Edge vs level
        bus_write(2'd1, 32'h3, 4'b0001);
        sw = 3'b011;
        repeat (12) tick();
        bus_read(2'd0, rd_obs, rd_exp);
        chk("lvl_edge_set", rd_obs, 32'd3);
        bus_write(2'd0, 32'h3, 4'b0001);
        bus_read(2'd0, rd_obs, rd_exp);
        chk("lvl_reset", rd_obs, 32'd2);

        // Priority
        bus_write(2'd2, 32'h7, 4'b0001);
        bus_write(2'd1, 32'h7, 4'b0001);
        sw = 3'b111;
        repeat (12) tick();
        bus_read(2'd0, rd_obs, rd_exp);
        chk("prio_pending", rd_obs, 32'd6);
        bus_read(2'd3, rd_obs, rd_exp);
        chk("active_110", rd_obs, 32'h8000_0001);
        bus_write(2'd1, 32'h5, 4'b0001);
        bus_read(2'd3, rd_obs, rd_exp);
        chk("active_mask101", rd_obs, 32'h8000_0002);

        // W1C colliding with a new edge event on source 2
        sw[2] = 1'b0;
        repeat (12) tick();
        sw[2] = 1'b1;
        repeat (D + 1) tick();
        bus_write(2'd0, 32'h4, 4'b0001);
        bus_read(2'd0, rd_obs, rd_exp);
        chk("collide_bit2", 32'(rd_obs[2]), 32'd1);
        chk("collide_model", rd_obs, rd_exp);

        // Back-to-back reads with valid held
        iomem_valid = 1'b1; iomem_addr = 32'h4; iomem_wstrb = 4'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("b2b_ready", 32'(iomem_ready), 32'(k % 2 == 0));
            chk("b2b_rdata", iomem_rdata, (k % 2 == 0) ? 32'd5 : 32'd0);
        end
        iomem_valid = 1'b0;
        bus_write(2'd1, 32'h0, 4'b0010);
        bus_write(2'd3, 32'hFF, 4'b0001);
        bus_read(2'd1, rd_obs, rd_exp);
        chk("strb_ignored", rd_obs, 32'd5);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    sw = 3'($urandom);
                    repeat ($urandom_range(1, 8)) tick();
                end
                1: bus_write(2'($urandom), 32'($urandom), 4'($urandom));
                2: begin
                    bus_read(2'($urandom), rd_obs, rd_exp);
                    chk("rand_read", rd_obs, rd_exp);
                end
                default: tick();
            endcase
        end

        // Reset in the middle of a write access
        sw = '0;
        iomem_valid = 1'b1; iomem_addr = 32'h4; iomem_wdata = 32'h7; iomem_wstrb = 4'b0001;
        tick();
        chk("mid_ready", 32'(iomem_ready), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(iomem_ready), 32'd0);
        iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        @(negedge clk);
        repeat (2) tick();
        resetn = 1'b1;
        bus_read(2'd1, rd_obs, rd_exp);
        chk("mid_rst_mask", rd_obs, 32'd0);
        bus_read(2'd0, rd_obs, rd_exp);
        chk("mid_rst_pending", rd_obs, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
